// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared types for the register-file write-back path: widths, register index
// and the write-back source identifiers.
package rf_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  typedef logic [RW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xdata_t;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_MDU = 2'd2
  } src_e;
endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Bundle of the three write-back request channels, the decode issue port,
// the pending-write scoreboard and the register-file write port.
interface rf_writeback_arbiter_if;
  import rf_pkg::*;

  logic            alu_valid, lsu_valid, mdu_valid;
  reg_idx_t        alu_rd, lsu_rd, mdu_rd;
  xdata_t          alu_data, lsu_data, mdu_data;
  logic            alu_ready, lsu_ready, mdu_ready;
  logic            iss_valid;
  reg_idx_t        iss_rd;
  logic [NREG-1:0] busy;
  logic            rf_we;
  reg_idx_t        rf_a3;
  xdata_t          rf_wd;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           mdu_valid, mdu_rd, mdu_data, iss_valid, iss_rd,
    input  alu_ready, lsu_ready, mdu_ready, busy, rf_we, rf_a3, rf_wd
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           mdu_valid, mdu_rd, mdu_data, iss_valid, iss_rd,
    output alu_ready, lsu_ready, mdu_ready, busy, rf_we, rf_a3, rf_wd
  );
endinterface

// File: rtl/rf_writeback_arbiter_wb_starve_counter.sv
// Counts consecutive cycles a source waits with a request up; once the count
// reaches STARVE_LIMIT the source is reported starved until it is served.
module wb_starve_counter
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_granted,
  output logic o_starved
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_count;

  // Saturating wait counter; any grant or dropped request restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_valid || i_granted) begin
      r_count <= '0;
    end else if (r_count != LIMIT) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign o_starved = (r_count == LIMIT);
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU/LSU/MDU write-backs onto the single register-file write port and
// tracks registers with a write still in flight for decode hazard checks.
module rf_writeback_arbiter
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_writeback_arbiter_if.slave wb
);
  logic            w_lsu_starved, w_mdu_starved;
  logic            w_xfer;
  src_e            w_src;
  reg_idx_t        w_rd;
  xdata_t          w_data;
  logic            w_alu_grant, w_lsu_grant, w_mdu_grant;
  logic [NREG-1:0] w_busy_set, w_busy_clr;

  logic            r_rf_we;
  reg_idx_t        r_rf_a3;
  xdata_t          r_rf_wd;
  logic [NREG-1:0] r_busy;

  // Starved sources jump ahead of the ALU; MDU outranks LSU when both starve.
  always_comb begin
    w_xfer = 1'b1;
    w_src  = SRC_ALU;
    if (rst) begin
      w_xfer = 1'b0;
    end else if (wb.mdu_valid && w_mdu_starved) begin
      w_src = SRC_MDU;
    end else if (wb.lsu_valid && w_lsu_starved) begin
      w_src = SRC_LSU;
    end else if (wb.alu_valid) begin
      w_src = SRC_ALU;
    end else if (wb.lsu_valid) begin
      w_src = SRC_LSU;
    end else if (wb.mdu_valid) begin
      w_src = SRC_MDU;
    end else begin
      w_xfer = 1'b0;
    end
  end

  always_comb begin
    w_rd   = wb.alu_rd;
    w_data = wb.alu_data;
    case (w_src)
      SRC_LSU: begin w_rd = wb.lsu_rd; w_data = wb.lsu_data; end
      SRC_MDU: begin w_rd = wb.mdu_rd; w_data = wb.mdu_data; end
      default: begin w_rd = wb.alu_rd; w_data = wb.alu_data; end
    endcase
  end

  assign w_alu_grant  = w_xfer && (w_src == SRC_ALU);
  assign w_lsu_grant  = w_xfer && (w_src == SRC_LSU);
  assign w_mdu_grant  = w_xfer && (w_src == SRC_MDU);
  assign wb.alu_ready = w_alu_grant;
  assign wb.lsu_ready = w_lsu_grant;
  assign wb.mdu_ready = w_mdu_grant;

  wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_lsu_starve (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (wb.lsu_valid),
    .i_granted (w_lsu_grant),
    .o_starved (w_lsu_starved)
  );

  wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_mdu_starve (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (wb.mdu_valid),
    .i_granted (w_mdu_grant),
    .o_starved (w_mdu_starved)
  );

  // Writes to x0 are accepted from the source but never reach the file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we <= 1'b0;
      r_rf_a3 <= '0;
      r_rf_wd <= '0;
    end else begin
      r_rf_we <= w_xfer && (w_rd != '0);
      if (w_xfer) begin
        r_rf_a3 <= w_rd;
        r_rf_wd <= w_data;
      end
    end
  end

  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (wb.iss_valid && (wb.iss_rd != '0)) w_busy_set[wb.iss_rd] = 1'b1;
    if (r_rf_we) w_busy_clr[r_rf_a3] = 1'b1;
  end

  // A new issue to the register being retired this edge keeps it pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & {{(NREG-1){1'b1}}, 1'b0};
    end
  end

  assign wb.rf_we = r_rf_we;
  assign wb.rf_a3 = r_rf_a3;
  assign wb.rf_wd = r_rf_wd;
  assign wb.busy  = r_busy;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed scenarios followed by random traffic, all checked every cycle
// against a cycle-level model of arbitration, write port and scoreboard.
module tb_rf_writeback_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rf_writeback_arbiter_if wb ();

  rf_writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  int          waitLsu, waitMdu;
  logic        expWe;
  logic [4:0]  expA3;
  logic [31:0] expWd;
  logic [31:0] expBusy;
  int          lastGrant;
  logic        obsAlu, obsLsu, obsMdu;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic r,
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic iv, input logic [4:0] ird);
    rst          = r;
    wb.alu_valid = av; wb.alu_rd = ard; wb.alu_data = ad;
    wb.lsu_valid = lv; wb.lsu_rd = lrd; wb.lsu_data = ld;
    wb.mdu_valid = mv; wb.mdu_rd = mrd; wb.mdu_data = md;
    wb.iss_valid = iv; wb.iss_rd = ird;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // 0 = none, 1 = ALU, 2 = LSU, 3 = MDU; "starved" = waited LIMIT cycles.
  function automatic int modelGrant();
    if (rst) return 0;
    if (wb.mdu_valid && waitMdu >= LIMIT) return 3;
    if (wb.lsu_valid && waitLsu >= LIMIT) return 2;
    if (wb.alu_valid) return 1;
    if (wb.lsu_valid) return 2;
    if (wb.mdu_valid) return 3;
    return 0;
  endfunction

  task automatic runCycle();
    int          g;
    logic [4:0]  gRd;
    logic [31:0] gData;
    logic        wasReset;
    #1;
    g = modelGrant();
    obsAlu = wb.alu_ready;
    obsLsu = wb.lsu_ready;
    obsMdu = wb.mdu_ready;
    checkOutput("alu_ready", obsAlu, g == 1);
    checkOutput("lsu_ready", obsLsu, g == 2);
    checkOutput("mdu_ready", obsMdu, g == 3);
    lastGrant = g;
    gRd   = (g == 2) ? wb.lsu_rd   : (g == 3) ? wb.mdu_rd   : wb.alu_rd;
    gData = (g == 2) ? wb.lsu_data : (g == 3) ? wb.mdu_data : wb.alu_data;
    wasReset = rst;
    @(posedge clk);
    if (wasReset) begin
      expWe = 0; expA3 = 0; expWd = 0; expBusy = 0; waitLsu = 0; waitMdu = 0;
    end else begin
      if (expWe) expBusy[expA3] = 1'b0;
      if (wb.iss_valid && wb.iss_rd != 0) expBusy[wb.iss_rd] = 1'b1;
      expWe = (g != 0) && (gRd != 0);
      if (expWe) begin expA3 = gRd; expWd = gData; end
      waitLsu = (wb.lsu_valid && g != 2) ? waitLsu + 1 : 0;
      waitMdu = (wb.mdu_valid && g != 3) ? waitMdu + 1 : 0;
    end
    @(negedge clk);
    checkOutput("rf_we", wb.rf_we, expWe);
    if (expWe || wasReset) begin
      checkOutput("rf_a3", wb.rf_a3, expA3);
      checkOutput("rf_wd", wb.rf_wd, expWd);
    end
    checkOutput("busy", wb.busy, expBusy);
  endtask

  initial begin
    int lsuGrant, mduGrant, mduGrant2;
    logic alv, lsv, mdv;
    logic [4:0] ard, lrd, mrd;
    logic [31:0] ad, ld, md;

    waitLsu = 0; waitMdu = 0; expWe = 0; expA3 = 0; expWd = 0; expBusy = 0;

    // Reset with every request raised: no readies, clean outputs.
    applyStimulus(1, 1, 3, 32'h11, 1, 4, 32'h22, 1, 6, 32'h33, 1, 9);
    runCycle();
    runCycle();

    // Single ALU write-back retiring an issued rd = 5.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    runCycle();
    checkOutput("busy5_set", wb.busy[5], 1);
    applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("alu5_ready", obsAlu, 1);
    checkOutput("alu5_wd", wb.rf_wd, 32'hDEADBEEF);
    applyIdle();
    runCycle();
    checkOutput("busy5_clear", wb.busy[5], 0);

    // Continuous ALU stream against one LSU request.
    lsuGrant = -1;
    ld = $urandom;
    for (int c = 0; c < 7; c++) begin
      applyStimulus(0, 1, 5'($urandom_range(1, 31)), $urandom, lsuGrant < 0, 9, ld,
                    0, 0, 0, 0, 0);
      runCycle();
      if (lsuGrant < 0 && obsLsu) lsuGrant = c;
    end
    checkOutput("lsu_starve_cycle", lsuGrant, LIMIT);

    // LSU and MDU both held off; MDU re-requests right after its grant.
    applyIdle();
    runCycle();
    lsuGrant = -1; mduGrant = -1; mduGrant2 = -1;
    md = $urandom;
    for (int c = 0; c < 11; c++) begin
      applyStimulus(0, 1, 5'($urandom_range(1, 31)), $urandom, lsuGrant < 0, 10, 32'hABCD,
                    1, 11, md, 0, 0);
      runCycle();
      if (lsuGrant < 0 && obsLsu) lsuGrant = c;
      if (obsMdu) begin
        if (mduGrant < 0) mduGrant = c;
        else if (mduGrant2 < 0) mduGrant2 = c;
        md = $urandom;
      end
    end
    checkOutput("both_mdu_first", mduGrant, LIMIT);
    checkOutput("both_lsu_next", lsuGrant, LIMIT + 1);
    checkOutput("mdu_counter_cleared", mduGrant2, 2 * LIMIT + 1);

    // Write to x0 and an issue to x0.
    applyIdle();
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 1, 0);
    runCycle();
    checkOutput("x0_ready", obsMdu, 1);
    checkOutput("x0_we", wb.rf_we, 0);
    checkOutput("x0_busy", wb.busy[0], 0);

    // Retiring rd = 7 in the same cycle it is issued again.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    runCycle();
    applyStimulus(0, 1, 7, 32'h7777, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    runCycle();
    checkOutput("collide_busy7", wb.busy[7], 1);
    applyIdle();
    runCycle();

    // Reset right after an LSU grant, with MDU part-way to starvation.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    runCycle();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 1, 3, $urandom, 0, 0, 0, 1, 13, 32'h5A5A, 0, 0);
      runCycle();
    end
    applyStimulus(0, 0, 0, 0, 1, 12, 32'hC0FFEE, 1, 13, 32'h5A5A, 0, 0);
    runCycle();
    checkOutput("pre_reset_we", wb.rf_we, 1);
    applyStimulus(1, 1, 3, 32'h1, 1, 12, 32'hC0FFEE, 1, 13, 32'h5A5A, 1, 14);
    runCycle();
    checkOutput("reset_we", wb.rf_we, 0);
    checkOutput("reset_busy", wb.busy, 0);
    mduGrant = -1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(0, 1, 5'($urandom_range(1, 31)), $urandom, 0, 0, 0,
                    mduGrant < 0, 13, 32'h5A5A, 0, 0);
      runCycle();
      if (mduGrant < 0 && obsMdu) mduGrant = c;
    end
    checkOutput("reset_counter_cleared", mduGrant, LIMIT);

    // Random traffic; sources hold each request until the model grants it.
    applyIdle();
    runCycle();
    alv = 0; lsv = 0; mdv = 0;
    ard = 0; lrd = 0; mrd = 0; ad = 0; ld = 0; md = 0;
    for (int c = 0; c < 400; c++) begin
      if (!alv && $urandom_range(0, 99) < 50) begin alv = 1; ard = 5'($urandom); ad = $urandom; end
      if (!lsv && $urandom_range(0, 99) < 60) begin lsv = 1; lrd = 5'($urandom); ld = $urandom; end
      if (!mdv && $urandom_range(0, 99) < 40) begin mdv = 1; mrd = 5'($urandom); md = $urandom; end
      applyStimulus($urandom_range(0, 63) == 0, alv, ard, ad, lsv, lrd, ld, mdv, mrd, md,
                    1'($urandom), 5'($urandom));
      runCycle();
      if (lastGrant == 1) alv = 0;
      if (lastGrant == 2) lsv = 0;
      if (lastGrant == 3) mdv = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
